pixel_mean_reciprocal_divider: RTL and testbench

- Downstream consumer of the reciprocal LUT. It accumulates a group of pixel values delimited by tlast.
- At group close it presents the pixel count to the LUT and takes the returned fractional reciprocal.
- It multiplies the group sum by that reciprocal, rounds, and emits the group mean on an AXI-stream-style output.
- Used for binning and averaging pixels ahead of the frame writer, with no hardware divider.

---
 rtl/pixel_mean_reciprocal_divider.sv | 165 ++++++++++++++++
 tb/tb_pixel_mean_reciprocal_divider.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mean_reciprocal_divider.sv
`default_nettype none
// ============================================================================
// Module   : pixel_mean_reciprocal_divider
// Purpose  : Accumulates a tlast-delimited group of unsigned pixels and
//            emits the rounded group mean. The division is replaced by a
//            multiply with a fractional reciprocal fetched from an external
//            LUT (count -> round(2^N_BITS_OUT / count)).
// Ports    : clk, rst_n                   clock, async active-low reset
//            s_pixel_tdata/tvalid/tlast   pixel input stream
//            s_pixel_tready               pixel accept (ACCUM state only)
//            number_out/number_out_tvalid group count request to the LUT
//            reciprocal_in/_tvalid        reciprocal answer from the LUT
//            m_mean_tdata/tvalid/tready   group mean output stream
//            group_truncated              1-cycle pulse on forced close
// Revision : 1.0 - initial release
// ============================================================================
module pixel_mean_reciprocal_divider #(
  parameter int PIXEL_W    = 12,
  parameter int N_BITS_IN  = 8,
  parameter int N_BITS_OUT = 16,
  parameter int SUM_W      = PIXEL_W + N_BITS_IN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_W-1:0]    s_pixel_tdata,
  input  logic                  s_pixel_tvalid,
  input  logic                  s_pixel_tlast,
  output logic                  s_pixel_tready,
  output logic [N_BITS_IN-1:0]  number_out,
  output logic                  number_out_tvalid,
  input  logic [N_BITS_OUT-1:0] reciprocal_in,
  input  logic                  reciprocal_in_tvalid,
  output logic [PIXEL_W-1:0]    m_mean_tdata,
  output logic                  m_mean_tvalid,
  input  logic                  m_mean_tready,
  output logic                  group_truncated
);

  localparam int PROD_W = SUM_W + N_BITS_OUT;

  localparam logic [N_BITS_IN-1:0] c_CNT_ONE  = N_BITS_IN'(1);
  localparam logic [N_BITS_IN-1:0] c_CNT_MAX  = {N_BITS_IN{1'b1}};
  localparam logic [PROD_W:0]      c_HALF     = (PROD_W+1)'(1) << (N_BITS_OUT-1);
  localparam logic [SUM_W:0]       c_MEAN_MAX = (SUM_W+1)'({PIXEL_W{1'b1}});

  typedef enum logic [2:0] {
    ST_ACCUM = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MULT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SUM_W-1:0]      r_sum;
  logic [N_BITS_IN-1:0]  r_count;
  logic [N_BITS_OUT-1:0] r_recip;
  logic [PROD_W-1:0]     r_product;
  logic                  r_trunc;

  logic                  w_pix_hs;
  logic [SUM_W-1:0]      w_sum_inc;
  logic [N_BITS_IN-1:0]  w_cnt_inc;
  logic                  w_hit_max;
  logic                  w_close;
  logic [PROD_W-1:0]     w_product;
  logic [SUM_W:0]        w_quot;
  logic [PIXEL_W-1:0]    w_clamped;
  logic                  w_bypass;

  // Ready is gated by rst_n so it reads 0 for the whole time reset is held,
  // not just after the first edge.
  assign s_pixel_tready = rst_n && (r_state == ST_ACCUM);
  assign w_pix_hs       = s_pixel_tvalid && s_pixel_tready;
  assign w_sum_inc      = r_sum + SUM_W'(s_pixel_tdata);
  assign w_cnt_inc      = r_count + c_CNT_ONE;
  assign w_hit_max      = (w_cnt_inc == c_CNT_MAX);
  assign w_close        = w_pix_hs && (s_pixel_tlast || w_hit_max);

  assign w_product = PROD_W'(r_sum) * PROD_W'(r_recip);
  // Round-half-up, then drop the fractional bits.
  assign w_quot    = (SUM_W+1)'(({1'b0, r_product} + c_HALF) >> N_BITS_OUT);
  assign w_clamped = (w_quot > c_MEAN_MAX) ? {PIXEL_W{1'b1}} : w_quot[PIXEL_W-1:0];

  // A single-pixel group skips the LUT; its mean is the pixel itself.
  // The count is held through OUT, so it identifies that case there.
  assign w_bypass  = (r_count == c_CNT_ONE);

  assign number_out        = r_count;
  assign number_out_tvalid = (r_state == ST_REQ);
  assign m_mean_tvalid     = (r_state == ST_OUT);
  assign m_mean_tdata      = (r_state != ST_OUT) ? '0 :
                             (w_bypass ? r_sum[PIXEL_W-1:0] : w_clamped);
  assign group_truncated   = r_trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_close) begin
          w_state_next = (w_cnt_inc == c_CNT_ONE) ? ST_OUT : ST_REQ;
        end
      end
      ST_REQ:  w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (reciprocal_in_tvalid) begin
          w_state_next = ST_MULT;
        end
      end
      ST_MULT: w_state_next = ST_OUT;
      ST_OUT: begin
        if (m_mean_tready) begin
          w_state_next = ST_ACCUM;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_count   <= '0;
      r_recip   <= '0;
      r_product <= '0;
      r_trunc   <= 1'b0;
    end else begin
      r_trunc <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (w_pix_hs) begin
            r_sum   <= w_sum_inc;
            r_count <= w_cnt_inc;
            r_trunc <= w_hit_max && !s_pixel_tlast;
          end
        end
        ST_WAIT: begin
          if (reciprocal_in_tvalid) begin
            r_recip <= reciprocal_in;
          end
        end
        ST_MULT: r_product <= w_product;
        ST_OUT: begin
          if (m_mean_tready) begin
            r_sum   <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_mean_reciprocal_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_mean_reciprocal_divider
// Purpose  : Directed self-checking bench for pixel_mean_reciprocal_divider,
//            with a behavioural reciprocal LUT of adjustable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_mean_reciprocal_divider;

  logic        clk;
  logic        rst_n;
  logic [11:0] s_pixel_tdata;
  logic        s_pixel_tvalid;
  logic        s_pixel_tlast;
  logic        s_pixel_tready;
  logic [7:0]  number_out;
  logic        number_out_tvalid;
  logic [15:0] reciprocal_in;
  logic        reciprocal_in_tvalid;
  logic [11:0] m_mean_tdata;
  logic        m_mean_tvalid;
  logic        m_mean_tready;
  logic        group_truncated;

  int checks;
  int errors;
  int lut_lat;
  int req_cnt;

  pixel_mean_reciprocal_divider #(
    .PIXEL_W    (12),
    .N_BITS_IN  (8),
    .N_BITS_OUT (16)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_pixel_tdata        (s_pixel_tdata),
    .s_pixel_tvalid       (s_pixel_tvalid),
    .s_pixel_tlast        (s_pixel_tlast),
    .s_pixel_tready       (s_pixel_tready),
    .number_out           (number_out),
    .number_out_tvalid    (number_out_tvalid),
    .reciprocal_in        (reciprocal_in),
    .reciprocal_in_tvalid (reciprocal_in_tvalid),
    .m_mean_tdata         (m_mean_tdata),
    .m_mean_tvalid        (m_mean_tvalid),
    .m_mean_tready        (m_mean_tready),
    .group_truncated      (group_truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lut_recip(input int n);
    int r;
    r = (65536 + n / 2) / n;
    if (r > 65535) r = 65535;
    return r[15:0];
  endfunction

  // Reciprocal LUT model: answers each request lut_lat cycles later.
  initial begin : lut_model
    int n;
    int lat;
    reciprocal_in        = '0;
    reciprocal_in_tvalid = 1'b0;
    req_cnt              = 0;
    forever begin
      @(negedge clk);
      if (number_out_tvalid === 1'b1) begin
        req_cnt++;
        n   = int'(number_out);
        lat = lut_lat;
        repeat (lat) @(posedge clk);
        #1;
        reciprocal_in        = lut_recip(n);
        reciprocal_in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        reciprocal_in_tvalid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pixel and returns #1 after the accepting edge.
  task automatic send_pix(input logic [11:0] d, input logic l);
    bit got;
    got            = 1'b0;
    s_pixel_tdata  = d;
    s_pixel_tvalid = 1'b1;
    s_pixel_tlast  = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_pixel_tready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL pixel_accept_timeout: tready=%0b want 1", s_pixel_tready);
    end
    @(posedge clk);
    #1;
    s_pixel_tvalid = 1'b0;
    s_pixel_tlast  = 1'b0;
  endtask

  // Waits (bounded) until m_mean_tvalid is seen at a sample point.
  task automatic wait_mean(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_mean_tvalid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: m_mean_tvalid=%0b want 1", name, m_mean_tvalid);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    s_pixel_tdata  = '0;
    s_pixel_tvalid = 1'b0;
    s_pixel_tlast  = 1'b0;
    m_mean_tready  = 1'b1;
    lut_lat        = 1;
    #2;
    checks++;
    if (s_pixel_tready !== 1'b0 || number_out_tvalid !== 1'b0 || m_mean_tvalid !== 1'b0 ||
        group_truncated !== 1'b0 || m_mean_tdata !== 12'd0 || number_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b nv=%0b mv=%0b tr=%0b md=%0d no=%0d want all 0",
               s_pixel_tready, number_out_tvalid, m_mean_tvalid, group_truncated,
               m_mean_tdata, number_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (s_pixel_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b want 1", s_pixel_tready);
    end
  endtask

  task automatic test_basic_mean();
    lut_lat = 1;
    send_pix(12'd100, 1'b0);
    send_pix(12'd200, 1'b0);
    send_pix(12'd300, 1'b0);
    send_pix(12'd400, 1'b1);
    // cycle k+1: REQ
    checks++;
    if (number_out_tvalid !== 1'b1 || number_out !== 8'd4 || s_pixel_tready !== 1'b0) begin
      errors++;
      $display("FAIL basic_req: nv=%0b no=%0d rdy=%0b want 1/4/0",
               number_out_tvalid, number_out, s_pixel_tready);
    end
    step(); // k+2: WAIT
    checks++;
    if (number_out_tvalid !== 1'b0 || number_out !== 8'd4) begin
      errors++;
      $display("FAIL basic_req_pulse: nv=%0b no=%0d want 0/4", number_out_tvalid, number_out);
    end
    step(); // k+3: MULT
    checks++;
    if (m_mean_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %0b want 0", m_mean_tvalid);
    end
    step(); // k+4: OUT
    checks++;
    if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd250) begin
      errors++;
      $display("FAIL basic_mean: mv=%0b md=%0d want 1/250", m_mean_tvalid, m_mean_tdata);
    end
    step(); // handshake done
    checks++;
    if (m_mean_tvalid !== 1'b0 || s_pixel_tready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return: mv=%0b rdy=%0b want 0/1", m_mean_tvalid, s_pixel_tready);
    end
  endtask

  task automatic test_rounding();
    send_pix(12'd2, 1'b0);
    send_pix(12'd2, 1'b0);
    send_pix(12'd1, 1'b1);
    wait_mean("round_a");
    checks++;
    if (m_mean_tdata !== 12'd2) begin
      errors++;
      $display("FAIL round_221: got %0d want 2", m_mean_tdata);
    end
    step();
    send_pix(12'd1, 1'b0);
    send_pix(12'd1, 1'b0);
    send_pix(12'd1, 1'b1);
    wait_mean("round_b");
    checks++;
    if (m_mean_tdata !== 12'd1) begin
      errors++;
      $display("FAIL round_111: got %0d want 1", m_mean_tdata);
    end
    step();
  endtask

  task automatic test_bypass();
    int req_before;
    req_before = req_cnt;
    send_pix(12'd4095, 1'b1);
    checks++;
    if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd4095 || number_out_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_mean: mv=%0b md=%0d nv=%0b want 1/4095/0",
               m_mean_tvalid, m_mean_tdata, number_out_tvalid);
    end
    step();
    step();
    checks++;
    if (req_cnt !== req_before || m_mean_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_no_lut: reqs=%0d mv=%0b want %0d/0", req_cnt, m_mean_tvalid, req_before);
    end
  endtask

  task automatic test_truncate();
    bit early;
    early = 1'b0;
    for (int i = 0; i < 254; i++) begin
      send_pix(12'd10, 1'b0);
      if (group_truncated !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL trunc_early: pulse seen before beat 255 want none");
    end
    send_pix(12'd10, 1'b0);
    checks++;
    if (group_truncated !== 1'b1 || number_out_tvalid !== 1'b1 || number_out !== 8'd255) begin
      errors++;
      $display("FAIL trunc_pulse: tr=%0b nv=%0b no=%0d want 1/1/255",
               group_truncated, number_out_tvalid, number_out);
    end
    step();
    checks++;
    if (group_truncated !== 1'b0) begin
      errors++;
      $display("FAIL trunc_width: got %0b want 0", group_truncated);
    end
    wait_mean("trunc");
    checks++;
    if (m_mean_tdata !== 12'd10) begin
      errors++;
      $display("FAIL trunc_mean: got %0d want 10", m_mean_tdata);
    end
    step();
    // 256th pixel starts a fresh single-pixel group
    send_pix(12'd7, 1'b1);
    checks++;
    if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd7) begin
      errors++;
      $display("FAIL trunc_new_group: mv=%0b md=%0d want 1/7", m_mean_tvalid, m_mean_tdata);
    end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    m_mean_tready = 1'b0;
    send_pix(12'd4, 1'b0);
    send_pix(12'd8, 1'b1);
    // Next pixel offered while the result is stalled
    s_pixel_tdata  = 12'd9;
    s_pixel_tvalid = 1'b1;
    s_pixel_tlast  = 1'b1;
    wait_mean("bp");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd6 || s_pixel_tready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles want 0 (mv=%0b md=%0d rdy=%0b)",
               bad, m_mean_tvalid, m_mean_tdata, s_pixel_tready);
    end
    m_mean_tready = 1'b1;
    step(); // handshake edge
    checks++;
    if (s_pixel_tready !== 1'b1 || m_mean_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_after: rdy=%0b mv=%0b want 1/0", s_pixel_tready, m_mean_tvalid);
    end
    step(); // pixel 9 accepted
    s_pixel_tvalid = 1'b0;
    s_pixel_tlast  = 1'b0;
    checks++;
    if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd9) begin
      errors++;
      $display("FAIL bp_next_pixel: mv=%0b md=%0d want 1/9", m_mean_tvalid, m_mean_tdata);
    end
    step();
  endtask

  task automatic test_lut_latency();
    lut_lat = 3;
    send_pix(12'd100, 1'b0);
    send_pix(12'd200, 1'b0);
    send_pix(12'd300, 1'b0);
    send_pix(12'd400, 1'b1);
    repeat (4) step(); // k+5
    checks++;
    if (m_mean_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat3_early: mv=%0b want 0 at k+5", m_mean_tvalid);
    end
    step(); // k+6
    checks++;
    if (m_mean_tvalid !== 1'b1 || m_mean_tdata !== 12'd250) begin
      errors++;
      $display("FAIL lat3_mean: mv=%0b md=%0d want 1/250", m_mean_tvalid, m_mean_tdata);
    end
    step();
    lut_lat = 1;
  endtask

  task automatic test_reset_mid();
    lut_lat = 3;
    send_pix(12'd50, 1'b0);
    send_pix(12'd60, 1'b1);
    step(); // k+2: WAIT
    checks++;
    if (number_out !== 8'd2 || s_pixel_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_wait: no=%0d rdy=%0b want 2/0", number_out, s_pixel_tready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_pixel_tready !== 1'b0 || number_out !== 8'd0 || number_out_tvalid !== 1'b0 ||
        m_mean_tvalid !== 1'b0 || m_mean_tdata !== 12'd0 || group_truncated !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: rdy=%0b no=%0d nv=%0b mv=%0b md=%0d tr=%0b want all 0",
               s_pixel_tready, number_out, number_out_tvalid, m_mean_tvalid,
               m_mean_tdata, group_truncated);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lut_lat = 1;
    step();
    step();
    send_pix(12'd8, 1'b0);
    send_pix(12'd8, 1'b1);
    wait_mean("rst_after");
    checks++;
    if (m_mean_tdata !== 12'd8) begin
      errors++;
      $display("FAIL rst_after_mean: got %0d want 8", m_mean_tdata);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_mean();
    test_rounding();
    test_bypass();
    test_truncate();
    test_backpressure();
    test_lut_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
